// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared types and constants for the serial PE feeder
package pe_pkg;

  localparam int DATA_W       = 16;
  localparam int ACC_W        = 32;
  localparam int PE_CTL_FIRST = 0;
  localparam int PE_CTL_LAST  = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/pe_result_slot.sv
// rtl/pe_result_slot.sv - one-entry valid/ready holding register for PE results
module pe_result_slot
  import pe_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_vld,
  input  logic [ACC_W-1:0]  cap_data,
  input  logic [ADDR_W-1:0] cap_addr,
  input  logic              out_wready,
  output logic              out_wen,
  output logic [ADDR_W-1:0] out_waddr,
  output logic [ACC_W-1:0]  out_wdata
);

  logic              wen_q,  wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ACC_W-1:0]  data_q, data_d;

  // A capture in the same cycle as an accepted write re-arms the request.
  always_comb begin
    wen_d  = wen_q;
    addr_d = addr_q;
    data_d = data_q;
    if (cap_vld) begin
      wen_d  = 1'b1;
      addr_d = cap_addr;
      data_d = cap_data;
    end else if (wen_q && out_wready) begin
      wen_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      wen_q  <= wen_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign out_wen   = wen_q;
  assign out_waddr = addr_q;
  assign out_wdata = data_q;

endmodule

// File: rtl/serial_pe_feeder.sv
// rtl/serial_pe_feeder.sv - sequences neuron/weight SRAM reads into a serial PE
module serial_pe_feeder
  import pe_pkg::*;
#(
  parameter int LEN_W   = 8,
  parameter int NADDR_W = 8,
  parameter int WADDR_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LEN_W-1:0]   vec_len,
  input  logic [LEN_W-1:0]   row_cnt,
  output logic               busy,
  output logic               done,
  output logic               nram_ren,
  output logic [NADDR_W-1:0] nram_addr,
  input  logic [DATA_W-1:0]  nram_rdata,
  output logic               wram_ren,
  output logic [WADDR_W-1:0] wram_addr,
  input  logic [DATA_W-1:0]  wram_rdata,
  output logic [DATA_W-1:0]  pe_neuron,
  output logic [DATA_W-1:0]  pe_weight,
  output logic [1:0]         pe_ctl,
  output logic               pe_vld_i,
  input  logic [ACC_W-1:0]   pe_result,
  input  logic               pe_vld_o,
  output logic               out_wen,
  output logic [LEN_W-1:0]   out_waddr,
  output logic [ACC_W-1:0]   out_wdata,
  input  logic               out_wready
);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   n_q, n_d;
  logic [LEN_W-1:0]   m_q, m_d;
  logic [LEN_W-1:0]   k_q, k_d;
  logic [LEN_W-1:0]   row_q, row_d;
  logic [LEN_W-1:0]   res_row_q, res_row_d;
  logic [WADDR_W-1:0] wptr_q, wptr_d;
  logic               outst_q, outst_d;
  logic               p_vld_q, p_vld_d;
  logic               p_first_q, p_first_d;
  logic               p_last_q, p_last_d;

  logic issue;
  logic elem_last;
  logic row_final;
  logic hs;

  assign hs        = out_wen & out_wready;
  assign elem_last = (k_q == n_q - LEN_W'(1));
  assign row_final = (row_q == m_q - LEN_W'(1));

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    m_d       = m_q;
    k_d       = k_q;
    row_d     = row_q;
    res_row_d = res_row_q;
    wptr_d    = wptr_q;
    outst_d   = outst_q;
    issue     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          n_d    = vec_len;
          m_d    = row_cnt;
          k_d    = '0;
          row_d  = '0;
          wptr_d = '0;
          state_d = (vec_len == '0 || row_cnt == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // A row's last element may only launch once the slot is guaranteed free.
        issue = !elem_last || !outst_q || hs;
        if (issue) begin
          wptr_d = wptr_q + WADDR_W'(1);
          if (elem_last) begin
            k_d       = '0;
            row_d     = row_q + LEN_W'(1);
            res_row_d = row_q;
            if (row_final) state_d = WAIT;
          end else begin
            k_d = k_q + LEN_W'(1);
          end
        end
      end
      WAIT: begin
        if (hs) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (issue && elem_last) outst_d = 1'b1;
    else if (hs)            outst_d = 1'b0;

    p_vld_d   = issue;
    p_first_d = issue && (k_q == '0);
    p_last_d  = issue && elem_last;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      n_q       <= '0;
      m_q       <= '0;
      k_q       <= '0;
      row_q     <= '0;
      res_row_q <= '0;
      wptr_q    <= '0;
      outst_q   <= 1'b0;
      p_vld_q   <= 1'b0;
      p_first_q <= 1'b0;
      p_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      m_q       <= m_d;
      k_q       <= k_d;
      row_q     <= row_d;
      res_row_q <= res_row_d;
      wptr_q    <= wptr_d;
      outst_q   <= outst_d;
      p_vld_q   <= p_vld_d;
      p_first_q <= p_first_d;
      p_last_q  <= p_last_d;
    end
  end

  assign busy      = (state_q == RUN) || (state_q == WAIT);
  assign done      = (state_q == DONE);
  assign nram_ren  = issue;
  assign wram_ren  = issue;
  assign nram_addr = issue ? NADDR_W'(k_q) : '0;
  assign wram_addr = issue ? wptr_q : '0;

  // SRAM data is only forwarded in cycles the PE consumes it.
  assign pe_neuron            = p_vld_q ? nram_rdata : '0;
  assign pe_weight            = p_vld_q ? wram_rdata : '0;
  assign pe_ctl[PE_CTL_FIRST] = p_first_q;
  assign pe_ctl[PE_CTL_LAST]  = p_last_q;
  assign pe_vld_i             = p_vld_q;

  pe_result_slot #(
    .ADDR_W (LEN_W)
  ) u_slot (
    .clk        (clk),
    .rst        (rst),
    .cap_vld    (pe_vld_o),
    .cap_data   (pe_result),
    .cap_addr   (res_row_q),
    .out_wready (out_wready),
    .out_wen    (out_wen),
    .out_waddr  (out_waddr),
    .out_wdata  (out_wdata)
  );

endmodule
